serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: walks one 1-bit full subtractor over a
// WIDTH-bit operand pair, LSB first, producing a - b - bin in WIDTH cycles.
// The borrow between bits lives in a register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one result bit per clock, borrow rippled through a register
// DONE  | single-cycle result-valid pulse, then back to IDLE

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // One-bit difference and borrow of A - B - Bin
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [IW-1:0]    idx;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  assign last_bit = (idx == IW'(WIDTH - 1));

  full_subtractor u_fs (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (borrow),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Operand shifters, borrow, bit index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            idx    <= '0;
          end
        end
        S_RUN: begin
          diff[idx] <= cell_d;
          borrow    <= cell_bout;
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          // idx stops at the last bit rather than wrapping past WIDTH-1
          if (last_bit) bout <= cell_bout;
          else          idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases, a
// start-during-RUN case, mid-operation reset and a random sweep against an
// arithmetic reference model.

module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {bout,diff} is the (W+1)-bit wrap of a - b - bin
  function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bi);
    logic [W:0] r;
    r = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    return r;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full operation: launch at a negedge, E0 is the following posedge.
  // Inputs are scrambled right after E0 to show they no longer matter.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bi, input bit verbose);
    int         j;
    bit         busy_ok;
    logic [W:0] exp;
    wait_idle();
    exp   = ref_sub(av, bv, bi);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    j       = 0;
    busy_ok = 1'b1;
    while (!done && j < W + 4) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      j++;
    end
    if (verbose || !done || j != W || !busy_ok || busy) begin
      check({tag, "_done_seen"}, 64'(done), 64'd1);
      check({tag, "_latency"}, 64'(j), 64'(W));
      check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    end
    check({tag, "_result"}, 64'({bout, diff}), 64'(exp));
  endtask

  initial begin
    int n;
    logic [W:0] exp;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #12;
    check("reset_outputs", 64'({busy, done, bout, diff}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 5 cycles, outputs at reset values throughout
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs", 64'({busy, done, bout, diff}), 64'd0);
    end

    // Directed cases
    do_op("d_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b1);
    check("d_5a_3c_diff", 64'(diff), 64'h1E);
    do_op("d_00_01", 8'h00, 8'h01, 1'b0, 1'b1);
    check("d_00_01_bout", 64'(bout), 64'd1);
    do_op("d_00_00_b1", 8'h00, 8'h00, 1'b1, 1'b1);
    check("d_00_00_b1_diff", 64'(diff), 64'hFF);
    do_op("d_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
    check("d_ff_ff_bout", 64'(bout), 64'd0);

    // Result holds after DONE while idle
    @(negedge clk);
    @(negedge clk);
    check("hold_after_done", 64'({busy, done, bout, diff}), 64'h000);

    // start during RUN is ignored
    wait_idle();
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    check("ign_done_seen", 64'(done), 64'd1);
    check("ign_result", 64'({bout, diff}), 64'h07F);
    // Assert start from the DONE cycle on; it takes effect once IDLE is reached
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    check("next_done_seen", 64'(done), 64'd1);
    check("next_result", 64'({bout, diff}), 64'h1F0);
    @(negedge clk);
    check("single_done_pulse", 64'(done), 64'd0);

    // Reset in the middle of RUN
    wait_idle();
    a = 8'hC3; b = 8'h11; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({busy, done, bout, diff}), 64'd0);
    n = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("rst_no_done", 64'(n), 64'd0);
    rst_n = 1'b1;
    do_op("after_rst", 8'h05, 8'h03, 1'b0, 1'b1);
    check("after_rst_diff", 64'(diff), 64'h02);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      do_op("rand", ra, rb, rbi, 1'b0);
    end

    // Boundary: largest borrow case
    do_op("b_00_ff_b1", 8'h00, 8'hFF, 1'b1, 1'b1);
    exp = ref_sub(8'h00, 8'hFF, 1'b1);
    check("b_00_ff_b1_model", 64'({bout, diff}), 64'(exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
